// File: rtl/left_rotate_pkg.sv
// Shared types, default widths and the rotate-left-by-one helper for the
// left-rotate sequencing controller.
package left_rotate_pkg;

   localparam int DEF_DW = 4;
   localparam int DEF_CW = 3;
   localparam int MAX_W  = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROT  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Rotates the low w bits of v left by one; bits at and above w come back zero.
   function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w) begin
            r[i] = (i == 0) ? v[w-1] : v[i-1];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/left_rotate_ctrl_rot_core.sv
// DW-bit rotate register: parallel load, or rotate left by one bit when enabled.
module rot_core
   import left_rotate_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic          en_i,
   input  logic [DW-1:0] d_i,
   output logic [DW-1:0] q_o
);

   logic [DW-1:0]    data_q;
   logic [DW-1:0]    data_d;
   logic [MAX_W-1:0] rot_wide;

   assign rot_wide = rotl1(MAX_W'(data_q), DW);

   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = d_i;
      end else if (en_i) begin
         data_d = rot_wide[DW-1:0];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; this one is reset because out_data is visible from reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/left_rotate_ctrl.sv
// Sequencing controller: accepts a word and a count, rotates it left once per
// clock through rot_core, then offers the result on a valid/ready port.
module left_rotate_ctrl
   import left_rotate_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int CW = DEF_CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [CW-1:0] in_cnt,
   input  logic          abort,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          busy,
   output logic [7:0]    done_cnt
);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    done_cnt_q, done_cnt_d;
   logic          load, rot_en;

   assign in_ready  = (state_q == IDLE) && !abort;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign done_cnt  = done_cnt_q;

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      done_cnt_d = done_cnt_q;
      load       = 1'b0;
      rot_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               load    = 1'b1;
               cnt_d   = in_cnt;
               state_d = (in_cnt == '0) ? DONE : ROT;
            end
         end
         ROT: begin
            if (abort) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               rot_en = 1'b1;
               cnt_d  = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (abort) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (out_ready) begin
               done_cnt_d = done_cnt_q + 8'd1;
               state_d    = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   rot_core #(
      .DW(DW)
   ) u_rot_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .en_i   (rot_en),
      .d_i    (in_data),
      .q_o    (out_data)
   );

endmodule
